// File: rtl/dma_bus_arbiter_if.sv
// Bus-request handshake bundle between the DMA controller / CPU memory port
// and dma_bus_arbiter. The arbiter sits on the slave modport.
// The statistics signals exist only when ARB_GRANT_STATS_EN is defined.
interface dma_bus_arbiter_if;
    logic        BR;
    logic        M2busy;
    logic        BG;
    logic        cpu_stall;
    logic        bus_sel_dma;
    logic [1:0]  arb_state;
    logic        grant_timeout;
`ifdef ARB_GRANT_STATS_EN
    logic [15:0] grant_cycles;
    logic [7:0]  grant_count;
`endif

    // Arbiter side: samples the request and busy lines, drives grant/status.
    modport slave (
        input  BR, M2busy,
        output BG, cpu_stall, bus_sel_dma, arb_state, grant_timeout
`ifdef ARB_GRANT_STATS_EN
        , output grant_cycles, grant_count
`endif
    );

    // Requester/memory side: drives the request and busy lines.
    modport master (
        output BR, M2busy,
        input  BG, cpu_stall, bus_sel_dma, arb_state, grant_timeout
`ifdef ARB_GRANT_STATS_EN
        , input grant_cycles, grant_count
`endif
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: responder side of the DMA bus-request handshake.
// Drains any in-flight memory access before granting the bus to the DMA,
// holds the CPU off while granted, and enforces a CPU cooldown window
// after each release. Optional grant statistics: ARB_GRANT_STATS_EN.
module dma_bus_arbiter #(
    parameter int MIN_CPU_CYCLES = 4,
    parameter int MAX_GRANT      = 32,
    parameter int CNT_W          = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    dma_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        GRANT    = 2'd2,
        COOLDOWN = 2'd3
    } state_e;

    localparam int              COOL_LOAD_I = (MIN_CPU_CYCLES > 0) ? MIN_CPU_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOL_LOAD_I);
    localparam logic [CNT_W-1:0] MAX_T      = CNT_W'(MAX_GRANT);

    state_e           state_q, state_d;
    // Shared counter: grant age in GRANT, remaining cooldown in COOLDOWN.
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset is immediate, even mid-grant.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. Ownership only moves while M2busy is low, so BG
    // can never toggle on a cycle where memory was still busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.BR) state_d = DRAIN;
            end
            DRAIN: begin
                if (!bus.BR) begin
                    state_d = IDLE;
                end else if (!bus.M2busy) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (!bus.BR && !bus.M2busy) begin
                    if (MIN_CPU_CYCLES == 0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = COOLDOWN;
                        cnt_d   = COOL_LOAD;
                    end
                end
            end
            COOLDOWN: begin
                // BR is deliberately ignored; a level-held request is seen
                // again from IDLE once the window expires.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode registered state only; no path from BR to BG.
    assign bus.BG            = (state_q == GRANT);
    assign bus.bus_sel_dma   = (state_q == GRANT);
    assign bus.cpu_stall     = (state_q == DRAIN) || (state_q == GRANT);
    assign bus.arb_state     = state_q;
    assign bus.grant_timeout = (state_q == GRANT) && (cnt_q == MAX_T);

`ifdef ARB_GRANT_STATS_EN
    logic [15:0] gcyc_q, gcyc_d;
    logic [7:0]  gent_q, gent_d;

    // Grant statistics: saturating cycle total and wrapping entry count.
    always_comb begin
        gcyc_d = gcyc_q;
        gent_d = gent_q;
        if (state_q == GRANT && gcyc_q != 16'hFFFF) gcyc_d = gcyc_q + 16'd1;
        if (state_q == DRAIN && state_d == GRANT)   gent_d = gent_q + 8'd1;
    end

    // Statistics registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gcyc_q <= '0;
            gent_q <= '0;
        end else begin
            gcyc_q <= gcyc_d;
            gent_q <= gent_d;
        end
    end

    assign bus.grant_cycles = gcyc_q;
    assign bus.grant_count  = gent_q;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Testbench for dma_bus_arbiter: directed vector table, hand-written
// timeout and async-reset sequences, then randomized traffic checked
// against a behavioural model. Honors ARB_GRANT_STATS_EN.
module tb_dma_bus_arbiter;

    localparam int MIN_CPU = 4;
    localparam int MAXG    = 32;

    logic Clk;
    logic Reset;
    int   n_pass;
    int   n_total;

    dma_bus_arbiter_if bus ();

    dma_bus_arbiter #(
        .MIN_CPU_CYCLES (MIN_CPU),
        .MAX_GRANT      (MAXG),
        .CNT_W          (8)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural model: mode 0 idle, 1 draining, 2 granted, 3 cooling down.
    int m_mode;
    int m_age;        // cycles already spent granted (unbounded)
    int m_cool_left;  // cooldown cycles still owed to the CPU
    int m_gcyc;
    int m_gent;

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_cool_left = 0; m_gcyc = 0; m_gent = 0;
    endtask

    task automatic model_step(input logic br, input logic busy);
        case (m_mode)
            0: if (br) m_mode = 1;
            1: begin
                if (!br) m_mode = 0;
                else if (!busy) begin
                    m_mode = 2; m_age = 0; m_gent = (m_gent + 1) % 256;
                end
            end
            2: begin
                if (m_gcyc < 65535) m_gcyc++;
                if (!br && !busy) begin
                    if (MIN_CPU == 0) m_mode = 0;
                    else begin m_mode = 3; m_cool_left = MIN_CPU; end
                end else m_age++;
            end
            default: begin
                m_cool_left--;
                if (m_cool_left == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        check("state", 32'(bus.arb_state), 32'(m_mode));
        check("bg", 32'(bus.BG), 32'(m_mode == 2));
        check("sel", 32'(bus.bus_sel_dma), 32'(m_mode == 2));
        check("stall", 32'(bus.cpu_stall), 32'(m_mode == 1 || m_mode == 2));
        check("timeout", 32'(bus.grant_timeout), 32'(m_mode == 2 && m_age == MAXG));
`ifdef ARB_GRANT_STATS_EN
        check("gcyc", 32'(bus.grant_cycles), 32'(m_gcyc));
        check("gcnt", 32'(bus.grant_count), 32'(m_gent));
`endif
    endtask

    // One clock: drive inputs after a negedge, step the model at the
    // edge, compare on the following negedge.
    task automatic tick(input logic br, input logic busy);
        bus.BR = br;
        bus.M2busy = busy;
        @(posedge Clk);
        model_step(br, busy);
        @(negedge Clk);
        check_model();
    endtask

    typedef struct {
        logic       br;
        logic       busy;
        logic [1:0] st;
        logic       bg;
        logic       stall;
    } vec_t;

    function automatic vec_t mk(input logic br, input logic busy, input logic [1:0] st,
                                input logic bg, input logic stall);
        vec_t v;
        v.br = br; v.busy = busy; v.st = st; v.bg = bg; v.stall = stall;
        return v;
    endfunction

    vec_t tbl[32];

    initial begin
        logic br_r;
        n_pass = 0; n_total = 0;
        model_reset();

        // Basic grant, then release with BR re-raised during cooldown.
        tbl[0]  = mk(1, 0, 2'd1, 0, 1);
        tbl[1]  = mk(1, 0, 2'd2, 1, 1);
        tbl[2]  = mk(0, 0, 2'd3, 0, 0);
        tbl[3]  = mk(1, 0, 2'd3, 0, 0);
        tbl[4]  = mk(1, 0, 2'd3, 0, 0);
        tbl[5]  = mk(1, 0, 2'd3, 0, 0);
        tbl[6]  = mk(1, 0, 2'd0, 0, 0);
        tbl[7]  = mk(1, 0, 2'd1, 0, 1);
        // Drain wait for 3 busy cycles.
        tbl[8]  = mk(1, 1, 2'd1, 0, 1);
        tbl[9]  = mk(1, 1, 2'd1, 0, 1);
        tbl[10] = mk(1, 1, 2'd1, 0, 1);
        tbl[11] = mk(1, 0, 2'd2, 1, 1);
        // BR falls while memory still busy: grant held.
        tbl[12] = mk(0, 1, 2'd2, 1, 1);
        tbl[13] = mk(0, 1, 2'd2, 1, 1);
        tbl[14] = mk(0, 0, 2'd3, 0, 0);
        tbl[15] = mk(0, 0, 2'd3, 0, 0);
        tbl[16] = mk(0, 0, 2'd3, 0, 0);
        tbl[17] = mk(0, 0, 2'd3, 0, 0);
        tbl[18] = mk(0, 0, 2'd0, 0, 0);
        // Withdrawn request during busy: no grant.
        tbl[19] = mk(1, 1, 2'd1, 0, 1);
        tbl[20] = mk(0, 1, 2'd0, 0, 0);
        tbl[21] = mk(0, 0, 2'd0, 0, 0);
        // BR and M2busy fall together in GRANT; BR re-raised as cooldown ends.
        tbl[22] = mk(1, 0, 2'd1, 0, 1);
        tbl[23] = mk(1, 0, 2'd2, 1, 1);
        tbl[24] = mk(1, 1, 2'd2, 1, 1);
        tbl[25] = mk(0, 0, 2'd3, 0, 0);
        tbl[26] = mk(0, 0, 2'd3, 0, 0);
        tbl[27] = mk(0, 0, 2'd3, 0, 0);
        tbl[28] = mk(0, 0, 2'd3, 0, 0);
        tbl[29] = mk(1, 0, 2'd0, 0, 0);
        tbl[30] = mk(1, 0, 2'd1, 0, 1);
        tbl[31] = mk(0, 0, 2'd0, 0, 0);

        // Power-on reset.
        Reset = 1'b1; bus.BR = 1'b0; bus.M2busy = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_state", 32'(bus.arb_state), 32'd0);
        check("rst_bg", 32'(bus.BG), 32'd0);
        check("rst_stall", 32'(bus.cpu_stall), 32'd0);
        check("rst_timeout", 32'(bus.grant_timeout), 32'd0);
        Reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 32; i++) begin
            tick(tbl[i].br, tbl[i].busy);
            check($sformatf("tbl%0d_state", i), 32'(bus.arb_state), 32'(tbl[i].st));
            check($sformatf("tbl%0d_bg", i), 32'(bus.BG), 32'(tbl[i].bg));
            check($sformatf("tbl%0d_stall", i), 32'(bus.cpu_stall), 32'(tbl[i].stall));
        end

        // Timeout: long hold, pulse exactly once at grant cycle 32.
        for (int i = 0; i < 42; i++) begin
            tick(1'b1, 1'b0);
            check("to_pulse", 32'(bus.grant_timeout), 32'(i == 33));
            check("to_bg", 32'(bus.BG), 32'(i >= 1));
        end
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);

        // Async reset between edges while granted.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("pre_rst_bg", 32'(bus.BG), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("arst_bg", 32'(bus.BG), 32'd0);
        check("arst_stall", 32'(bus.cpu_stall), 32'd0);
        check("arst_sel", 32'(bus.bus_sel_dma), 32'd0);
        check("arst_state", 32'(bus.arb_state), 32'd0);
`ifdef ARB_GRANT_STATS_EN
        check("arst_gcyc", 32'(bus.grant_cycles), 32'd0);
        check("arst_gcnt", 32'(bus.grant_count), 32'd0);
`endif
        bus.BR = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        br_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) br_r = ~br_r;
            tick(br_r, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Responder side of the DMA bus-request handshake.
- Samples BR from the DMA controller and drains any in-flight CPU memory transaction, then grants the memory bus with BG and holds the CPU off the bus while granted.
- Guarantees the CPU a minimum number of bus cycles after each DMA release.
- Sits between the CPU memory port, the DMA controller and memory M2; drives the bus-owner select.

Parameters:
- MIN_CPU_CYCLES, 4: cycles the CPU owns the bus after BR deasserts before a new grant may be issued; 0 disables cooldown.
- MAX_GRANT, 32: grant-hold cycles after which grant_timeout pulses.
- CNT_W, 8: width of internal counters; MIN_CPU_CYCLES and MAX_GRANT must be < 2^CNT_W.

Ports:
- Clk  input  1  system clock, all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- BR  input  1  bus request from the DMA controller, level-held until transfer done.
- M2busy  input  1  memory M2 is completing an access; the bus may not change owner while high.
- BG  output  1  bus grant to the DMA controller (registered).
- cpu_stall  output  1  CPU must not start a new memory access.
- bus_sel_dma  output  1  memory address/data mux select: 1 = DMA, 0 = CPU; equals BG.
- arb_state  output  2  current state encoding, for debug/verification.
- grant_timeout  output  1  one-cycle pulse when a grant reaches MAX_GRANT cycles.

Behaviour:
- Reset (async, any state): state=IDLE, BG=0, bus_sel_dma=0, cpu_stall=0, grant_timeout=0, all counters 0. Takes effect immediately, including mid-grant.
- States and encodings: IDLE=0, DRAIN=1, GRANT=2, COOLDOWN=3.
- All outputs are decoded from registered state only; there is no combinational path from BR to BG.
- IDLE:
  - Outputs: BG=0, cpu_stall=0.
  - BR=1 -> DRAIN.
- DRAIN:
  - Outputs: BG=0, cpu_stall=1.
  - BR=0 -> IDLE (request withdrawn; no grant issued).
  - BR=1 and M2busy=0 -> GRANT.
  - BR=1 and M2busy=1 -> stay in DRAIN.
  - Minimum BR-to-BG latency: BR sampled high at edge N gives BG=1 after edge N+1.
- GRANT:
  - Outputs: BG=1, bus_sel_dma=1, cpu_stall=1.
  - Grant counter clears on entry and increments every cycle, saturating at all-ones.
  - grant_timeout=1 for exactly the one cycle in which the counter equals MAX_GRANT. The grant is not revoked.
  - BR=0 and M2busy=0 -> COOLDOWN, or -> IDLE if MIN_CPU_CYCLES=0.
  - BR=0 and M2busy=1 -> stay in GRANT until the DMA's last memory write retires.
  - BG falls on the edge after the exit condition is sampled.
- COOLDOWN:
  - Outputs: BG=0, cpu_stall=0.
  - Counter loads MIN_CPU_CYCLES-1 on entry and decrements each cycle.
  - BR is ignored; a request raised here is held off, not lost, because BR is level.
  - Counter=0 -> IDLE. If BR is still high in IDLE it then proceeds to DRAIN.
- Simultaneous events:
  - BR falling and M2busy falling in the same cycle in GRANT -> exit taken that edge.
  - BR re-asserted in the same cycle COOLDOWN expires -> IDLE first, then DRAIN; no state is skipped.
- Invariants:
  - BG=1 implies cpu_stall=1.
  - BG never changes on a cycle where M2busy=1 was sampled.

Optional Feature:
- Macro: ARB_GRANT_STATS_EN.
- Defined:
  - Extra output grant_cycles [15:0] holds the total GRANT-state cycles since reset, saturating at 16'hFFFF.
  - Extra output grant_count [7:0] holds the number of GRANT entries, wrapping modulo 256.
  - Both outputs are 0 on reset.
- Undefined: neither port exists and no counter logic is generated; all other behaviour is identical.

Test Plan:
- Basic grant: Reset, then BR=1 with M2busy=0 -> arb_state 0->1->2; BG=1 two edges after BR; cpu_stall=1 from the DRAIN cycle.
- Drain wait: BR=1 while M2busy=1 for 3 cycles -> stays in DRAIN for 3 cycles with BG=0; BG rises the edge after M2busy=0.
- Release and cooldown (MIN_CPU_CYCLES=4): drop BR with M2busy=0, and raise BR again 1 cycle later -> BG=0, cpu_stall=0 for 4 COOLDOWN cycles, then IDLE, DRAIN, GRANT.
- Withdraw and late busy: BR pulsed for 1 cycle during M2busy=1 -> DRAIN then IDLE, BG never asserts. Separately, BR falls while M2busy=1 in GRANT -> BG held until M2busy=0.
- Timeout (MAX_GRANT=32): hold BR for 40 cycles -> grant_timeout high exactly 1 cycle, at grant cycle 32; BG stays 1 throughout.
- Async reset mid-grant: assert Reset between clock edges while BG=1 -> BG, cpu_stall and bus_sel_dma go 0 immediately, arb_state=0. With ARB_GRANT_STATS_EN defined, grant_cycles=0 and grant_count=0.
